learn_judge: RTL and testbench

LEARN_JUDGE -- requirements
Module: learn_judge

---
 rtl/learn_pkg.sv | 27 ++
 rtl/learn_tick_gen.sv | 26 ++
 rtl/learn_judge.sv | 235 +++++++++++++++++++++++
 tb/tb_learn_judge.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/learn_pkg.sv
// Shared types for the note-learning judge: FSM states, grade codes and points table.
package learn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_NOTE,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam logic [2:0] GRADE_S    = 3'd0;
    localparam logic [2:0] GRADE_A    = 3'd1;
    localparam logic [2:0] GRADE_B    = 3'd2;
    localparam logic [2:0] GRADE_C    = 3'd3;
    localparam logic [2:0] GRADE_MISS = 3'd4;

    function automatic logic [2:0] grade_points(input logic [2:0] g);
        case (g)
            GRADE_S: grade_points = 3'd4;
            GRADE_A: grade_points = 3'd3;
            GRADE_B: grade_points = 3'd2;
            GRADE_C: grade_points = 3'd1;
            default: grade_points = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/learn_tick_gen.sv
// Free-running divider: one-cycle tick strobe every TICK_DIV clk cycles.
module learn_tick_gen #(
    parameter int TICK_DIV = 100000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt_reg <= '0;
        else if (cnt_reg == LAST)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + CW'(1);
    end

    assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/learn_judge.sv
// Timing judge for a play-along song: grades key presses against ROM notes.
// Optional LEARN_COMBO_EN adds a combo counter, combo bonus and combo output.
module learn_judge #(
    parameter int ADDR_W    = 5,
    parameter int NOTE_W    = 4,
    parameter int DUR_W     = 16,
    parameter int TICK_DIV  = 100000,
    parameter int GAP_TICKS = 200,
    parameter int SCORE_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NOTE_W-1:0]  key_note,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [NOTE_W-1:0]  rom_note,
    input  logic [DUR_W-1:0]   rom_dur,
    output logic [NOTE_W-1:0]  target_note,
    output logic               tone_en,
    output logic [2:0]         grade,
    output logic               grade_valid,
    output logic [SCORE_W-1:0] score,
    output logic [7:0]         miss_cnt,
`ifdef LEARN_COMBO_EN
    output logic [7:0]         combo,
`endif
    output logic               done
);
    import learn_pkg::*;

    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    logic tick;

    learn_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [DUR_W-1:0]   elapsed_reg, elapsed_next;
    logic [GW-1:0]      gap_reg, gap_next;
    logic               hit_reg, hit_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic [7:0]         miss_reg, miss_next;
    logic [2:0]         grade_reg, grade_next;
    logic               gv_reg, gv_next;
    logic [NOTE_W-1:0]  prev_key_reg;
`ifdef LEARN_COMBO_EN
    logic [7:0]         combo_reg, combo_next;
`endif

    // Grading arithmetic is done two bits wider so 4E and 3D cannot overflow.
    logic [DUR_W+1:0] e4, e2, d1, d3;
    logic [DUR_W-1:0] dur_eff;
    logic             press, win_end;
    logic [2:0]       hit_grade;

    assign e4        = {elapsed_reg, 2'b00};
    assign e2        = {1'b0, elapsed_reg, 1'b0};
    assign d1        = {2'b00, rom_dur};
    assign d3        = d1 + {1'b0, rom_dur, 1'b0};
    assign dur_eff   = (rom_dur == '0) ? DUR_W'(1) : rom_dur;
    assign win_end   = (elapsed_reg >= dur_eff);
    assign press     = (key_note != '0) && (key_note != prev_key_reg);
    assign hit_grade = (e4 < d1) ? GRADE_S :
                       (e2 < d1) ? GRADE_A :
                       (e4 < d3) ? GRADE_B : GRADE_C;

    logic             award, combo_clr;
    logic [2:0]       award_grade;
    logic [1:0]       miss_add;
    logic [3:0]       pts_total;
    logic [SCORE_W:0] score_sum;
    logic [8:0]       miss_sum;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        elapsed_next = elapsed_reg;
        gap_next     = gap_reg;
        hit_next     = hit_reg;
        score_next   = score_reg;
        miss_next    = miss_reg;
        grade_next   = grade_reg;
        gv_next      = 1'b0;
        award        = 1'b0;
        award_grade  = grade_reg;
        combo_clr    = 1'b0;
        miss_add     = 2'd0;
        pts_total    = 4'd0;
        score_sum    = '0;
        miss_sum     = '0;
`ifdef LEARN_COMBO_EN
        combo_next   = combo_reg;
`endif

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next   = ST_NOTE;
                    addr_next    = '0;
                    score_next   = '0;
                    miss_next    = '0;
                    grade_next   = 3'd0;
                    elapsed_next = '0;
                    hit_next     = 1'b0;
`ifdef LEARN_COMBO_EN
                    combo_next   = '0;
`endif
                end
            end
            ST_NOTE: begin
                if (rom_note == '0) begin
                    state_next = ST_DONE;
                end else begin
                    if (tick)
                        elapsed_next = elapsed_reg + DUR_W'(1);
                    if (press && !hit_reg) begin
                        if (key_note == rom_note) begin
                            award       = 1'b1;
                            award_grade = hit_grade;
                            hit_next    = 1'b1;
                        end else begin
                            miss_add  = miss_add + 2'd1;
                            combo_clr = 1'b1;
                        end
                    end
                    // A matching press on the closing cycle wins over MISS.
                    if (win_end) begin
                        if (!hit_reg && !award) begin
                            grade_next = GRADE_MISS;
                            gv_next    = 1'b1;
                            miss_add   = miss_add + 2'd1;
                            combo_clr  = 1'b1;
                        end
                        state_next = ST_GAP;
                        gap_next   = '0;
                    end
                end
            end
            ST_GAP: begin
                if (press) begin
                    miss_add  = 2'd1;
                    combo_clr = 1'b1;
                end
                if (tick)
                    gap_next = gap_reg + GW'(1);
                if (gap_reg >= GW'(GAP_TICKS)) begin
                    if (addr_reg == '1) begin
                        state_next = ST_DONE;
                    end else begin
                        addr_next    = addr_reg + ADDR_W'(1);
                        state_next   = ST_NOTE;
                        elapsed_next = '0;
                        hit_next     = 1'b0;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (award) begin
            pts_total = {1'b0, grade_points(award_grade)};
`ifdef LEARN_COMBO_EN
            if (combo_reg >= 8'd4)
                pts_total = pts_total + 4'd1;
            if (award_grade == GRADE_S || award_grade == GRADE_A)
                combo_next = (combo_reg == 8'hFF) ? combo_reg : combo_reg + 8'd1;
            else
                combo_next = '0;
`endif
            score_sum  = {1'b0, score_reg} + (SCORE_W+1)'(pts_total);
            score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            grade_next = award_grade;
            gv_next    = 1'b1;
        end
`ifdef LEARN_COMBO_EN
        if (combo_clr)
            combo_next = '0;
`endif

        if (miss_add != 2'd0) begin
            miss_sum  = {1'b0, miss_reg} + 9'(miss_add);
            miss_next = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            elapsed_reg  <= '0;
            gap_reg      <= '0;
            hit_reg      <= 1'b0;
            score_reg    <= '0;
            miss_reg     <= '0;
            grade_reg    <= 3'd0;
            gv_reg       <= 1'b0;
            prev_key_reg <= '0;
`ifdef LEARN_COMBO_EN
            combo_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            elapsed_reg  <= elapsed_next;
            gap_reg      <= gap_next;
            hit_reg      <= hit_next;
            score_reg    <= score_next;
            miss_reg     <= miss_next;
            grade_reg    <= grade_next;
            gv_reg       <= gv_next;
            prev_key_reg <= key_note;
`ifdef LEARN_COMBO_EN
            combo_reg    <= combo_next;
`endif
        end
    end

    assign rom_addr    = addr_reg;
    assign target_note = (state_reg == ST_NOTE) ? rom_note : '0;
    assign tone_en     = (state_reg == ST_NOTE) && hit_reg;
    assign grade       = grade_reg;
    assign grade_valid = gv_reg;
    assign score       = score_reg;
    assign miss_cnt    = miss_reg;
    assign done        = (state_reg == ST_DONE);
`ifdef LEARN_COMBO_EN
    assign combo       = combo_reg;
`endif

endmodule

// File: tb/tb_learn_judge.sv
// Directed bench for learn_judge with TICK_DIV=2, GAP_TICKS=3 and an 8-tick note.
module tb_learn_judge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  key_note = '0;
    logic [4:0]  rom_addr;
    logic [3:0]  rom_note;
    logic [15:0] rom_dur;
    logic [3:0]  target_note;
    logic        tone_en;
    logic [2:0]  grade;
    logic        grade_valid;
    logic [15:0] score;
    logic [7:0]  miss_cnt;
    logic        done;
`ifdef LEARN_COMBO_EN
    logic [7:0]  combo;
`endif

    logic [3:0]  song_note [32];
    logic [15:0] song_dur  [32];
    assign rom_note = song_note[rom_addr];
    assign rom_dur  = song_dur[rom_addr];

    learn_judge #(
        .ADDR_W(5), .NOTE_W(4), .DUR_W(16), .TICK_DIV(2), .GAP_TICKS(3), .SCORE_W(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .key_note    (key_note),
        .rom_addr    (rom_addr),
        .rom_note    (rom_note),
        .rom_dur     (rom_dur),
        .target_note (target_note),
        .tone_en     (tone_en),
        .grade       (grade),
        .grade_valid (grade_valid),
        .score       (score),
        .miss_cnt    (miss_cnt),
`ifdef LEARN_COMBO_EN
        .combo       (combo),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int gv_count = 0;
    int gv_base;
    logic [2:0] last_grade = '0;
    int cur_j;

    // Grade pulses are collected just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (grade_valid) begin
            gv_count++;
            last_grade = grade;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic clear_song();
        for (int i = 0; i < 32; i++) begin
            song_note[i] = '0;
            song_dur[i]  = 16'd8;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic goto(input int j);
        while (cur_j < j) begin
            @(negedge clk);
            cur_j++;
        end
    endtask

    task automatic wait_target(input bit want_nonzero, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((target_note != '0) == want_nonzero) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check(tag, found, 1);
        cur_j = 0;
    endtask

    task automatic wait_done(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, found, 1);
    endtask

    task automatic press_at(input int j, input logic [3:0] note);
        goto(j);
        key_note = note;
        goto(j + 1);
        key_note = '0;
    endtask

    initial begin
        clear_song();
        do_reset();
        check("rst_addr", rom_addr, 0);
        check("rst_score", score, 0);
        check("rst_miss", miss_cnt, 0);
        check("rst_grade", grade, 0);
        check("rst_gv", grade_valid, 0);
        check("rst_tone", tone_en, 0);
        check("rst_done", done, 0);
        check("rst_target", target_note, 0);

        // Early correct press -> S
        clear_song();
        song_note[0] = 4'd3;
        do_reset();
        gv_base = gv_count;
        pulse_start();
        wait_target(1'b1, "s_enter_tmo");
        check("s_target", target_note, 3);
        press_at(1, 4'd3);
        goto(3);
        check("s_tone_on", tone_en, 1);
        check("s_score", score, 4);
        check("s_grade", last_grade, 0);
        goto(14);
        check("s_tone_e7", tone_en, 1);
        wait_target(1'b0, "s_gap_tmo");
        check("s_tone_gap", tone_en, 0);
        wait_done("s_done");
        check("s_gv_cnt", gv_count - gv_base, 1);
        check("s_addr", rom_addr, 1);
        check("s_miss", miss_cnt, 0);

        // Late press (elapsed 6/7) -> C, repeated press ignored
        do_reset();
        gv_base = gv_count;
        pulse_start();
        wait_target(1'b1, "c_enter_tmo");
        press_at(13, 4'd3);
        press_at(15, 4'd3);
        wait_done("c_done");
        check("c_gv_cnt", gv_count - gv_base, 1);
        check("c_grade", last_grade, 3);
        check("c_score", score, 1);
        check("c_miss", miss_cnt, 0);

        // No press -> MISS
        do_reset();
        gv_base = gv_count;
        pulse_start();
        wait_target(1'b1, "m_enter_tmo");
        wait_target(1'b0, "m_gap_tmo");
        check("m_gap_addr", rom_addr, 0);
        check("m_gap_grade", last_grade, 4);
        wait_done("m_done");
        check("m_gv_cnt", gv_count - gv_base, 1);
        check("m_miss", miss_cnt, 1);
        check("m_score", score, 0);
        check("m_addr", rom_addr, 1);

        // Wrong then correct at elapsed 4/5 -> B
        do_reset();
        gv_base = gv_count;
        pulse_start();
        wait_target(1'b1, "b_enter_tmo");
        press_at(5, 4'd7);
        goto(7);
        check("b_miss_wrong", miss_cnt, 1);
        press_at(9, 4'd3);
        wait_done("b_done");
        check("b_gv_cnt", gv_count - gv_base, 1);
        check("b_grade", last_grade, 2);
        check("b_score", score, 2);
        check("b_miss", miss_cnt, 1);

        // Three-note song, restart from DONE, GAP press, mid-song reset
        clear_song();
        song_note[0] = 4'd3;
        song_note[1] = 4'd5;
        song_note[2] = 4'd6;
        do_reset();
        gv_base = gv_count;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_target(1'b1, "song_enter_tmo");
            press_at(1, song_note[k]);
            wait_target(1'b0, "song_gap_tmo");
        end
        wait_done("song_done");
        check("song_gv_cnt", gv_count - gv_base, 3);
        check("song_score", score, 12);
        check("song_addr", rom_addr, 3);
        pulse_start();
        check("restart_score", score, 0);
        check("restart_done", done, 0);
        wait_target(1'b1, "restart_enter_tmo");
        press_at(1, 4'd3);
        wait_target(1'b0, "restart_gap_tmo");
        key_note = 4'd9;
        @(negedge clk);
        key_note = '0;
        @(negedge clk);
        check("gap_press_miss", miss_cnt, 1);
        wait_target(1'b1, "second_note_tmo");
        check("second_addr", rom_addr, 1);
        goto(4);
        reset = 1'b1;
        goto(5);
        check("abort_addr", rom_addr, 0);
        check("abort_score", score, 0);
        check("abort_miss", miss_cnt, 0);
        check("abort_grade", grade, 0);
        check("abort_tone", tone_en, 0);
        check("abort_target", target_note, 0);
        reset = 1'b0;
        gv_base = gv_count;
        repeat (30) @(negedge clk);
        check("abort_no_gv", gv_count - gv_base, 0);
        check("abort_idle_done", done, 0);
        check("abort_idle_target", target_note, 0);

`ifdef LEARN_COMBO_EN
        begin
            int exp_sc [5] = '{4, 8, 12, 16, 21};
            clear_song();
            for (int k = 0; k < 5; k++) song_note[k] = 4'd3;
            do_reset();
            pulse_start();
            for (int k = 0; k < 5; k++) begin
                wait_target(1'b1, "combo_enter_tmo");
                press_at(1, 4'd3);
                goto(3);
                check("combo_score", score, exp_sc[k]);
                wait_target(1'b0, "combo_gap_tmo");
            end
            check("combo_count", combo, 5);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
